// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the unified-memory port arbiter.
//   arb_state_t  : arbiter sequencing states (IDLE, BUSY, DONE)
//   arb_gnt_t    : which requester owns the memory (GNT_IF fetch, GNT_DM data)
//   ARB_ERR_WORD : read data returned when the watchdog abandons a transaction
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_t;

    localparam logic [31:0] ARB_ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts BUSY cycles without a memory acknowledge and flags expiry.
// Only instantiated when ARB_WATCHDOG_EN is defined.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : pulse on the cycle a grant is issued (counter clears)
//   busy     : arbiter is in BUSY
//   ack      : memory acknowledge
//   expire   : BUSY has lasted TIMEOUT unacknowledged cycles
module arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Saturates at TIMEOUT so expiry stays asserted until the FSM leaves BUSY.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (busy && !ack && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = busy && (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the IF and
// MEM stages. Grants one requester at a time (alternating on ties), drives the
// memory handshake, returns read data with a one-cycle valid pulse and produces
// per-stage stall signals.
// Optional feature macro: ARB_WATCHDOG_EN (abandon BUSY after TIMEOUT cycles,
// return ARB_ERR_WORD and set sticky arb_err). Undefined: waits forever, arb_err=0.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   if_req/if_addr                    : fetch request (level) and address
//   if_rdata/if_valid/if_stall        : fetched word, valid pulse, stall
//   dm_req/dm_we/dm_bw/dm_addr/dm_wdata : data request and fields
//   dm_rdata/dm_valid/dm_stall        : load data, completion pulse, stall
//   mem_req/mem_we/mem_bw/mem_addr/mem_wdata : registered memory request
//   mem_rdata/mem_ack                 : memory response
//   arb_err                           : sticky watchdog timeout flag
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic          dm_bw,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_bw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          arb_err
);

    arb_state_t state;
    arb_gnt_t   grant;
    arb_gnt_t   last_grant;
    logic       pick_dm;
    logic       grant_now;
    logic       wd_expire;

    // On a tie, DM wins unless it was the last one served.
    assign pick_dm   = dm_req && (!if_req || (last_grant == GNT_IF));
    assign grant_now = (state == ST_IDLE) && (if_req || dm_req);

`ifdef ARB_WATCHDOG_EN
    logic arb_err_q;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .start (grant_now),
        .busy  (state == ST_BUSY),
        .ack   (mem_ack),
        .expire(wd_expire)
    );

    assign arb_err = arb_err_q;
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign arb_err        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= GNT_IF;
            last_grant <= GNT_IF;
            mem_we     <= 1'b0;
            mem_bw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
`ifdef ARB_WATCHDOG_EN
            arb_err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        grant     <= pick_dm ? GNT_DM : GNT_IF;
                        mem_addr  <= pick_dm ? dm_addr : if_addr;
                        mem_we    <= pick_dm && dm_we;
                        mem_bw    <= pick_dm && dm_bw;
                        mem_wdata <= pick_dm ? dm_wdata : '0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A real ack in the expiry cycle takes precedence.
                    if (mem_ack) begin
                        if (grant == GNT_DM) dm_rdata <= mem_rdata;
                        else                 if_rdata <= mem_rdata;
                        state <= ST_DONE;
                    end else if (wd_expire) begin
                        if (grant == GNT_DM) dm_rdata <= DW'(ARB_ERR_WORD);
                        else                 if_rdata <= DW'(ARB_ERR_WORD);
`ifdef ARB_WATCHDOG_EN
                        arb_err_q <= 1'b1;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req  = (state == ST_BUSY);
    assign if_valid = (state == ST_DONE) && (grant == GNT_IF);
    assign dm_valid = (state == ST_DONE) && (grant == GNT_DM);
    assign if_stall = if_req && !if_valid;
    assign dm_stall = dm_req && !dm_valid;

endmodule
